// File: rtl/cam_ctrl_pkg.sv
// Shared state encoding and default sizing for the camera capture controller.
package cam_ctrl_pkg;

  localparam int TIMEOUT_FRAMES_DEF = 4;
  localparam int CNT_W_DEF          = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_HOLD    = 3'd3,
    ST_ERROR   = 3'd4
  } cam_state_e;

  // States in which the CPU may own the frame buffer.
  function automatic logic grant_state(input cam_state_e s);
    return (s == ST_IDLE) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/cam_capture_ctrl_if.sv
// Control/status bundle between CPU/camera side (master) and the capture controller (slave).
interface cam_capture_ctrl_if
  import cam_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             start;
  logic             mode;
  logic             abort;
  logic             vsync;
  logic             done_image;
  logic             cpu_req;
  logic             cam_init;
  logic             cpu_gnt;
  logic             busy;
  logic             irq;
  logic             timeout;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output start, mode, abort, vsync, done_image, cpu_req,
    input  cam_init, cpu_gnt, busy, irq, timeout, frame_cnt
  );

  modport slave (
    input  start, mode, abort, vsync, done_image, cpu_req,
    output cam_init, cpu_gnt, busy, irq, timeout, frame_cnt
  );
endinterface

// File: rtl/cam_edge_det.sv
// Registered edge detector; the history register always tracks the input, reset or not.
module cam_edge_det
  import cam_ctrl_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         pclk,
  input  logic [W-1:0] sig,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);
  logic [W-1:0] sig_q;

  always_ff @(posedge pclk) begin
    sig_q <= sig;
  end

  assign rise = sig & ~sig_q;
  assign fall = sig_q & ~sig;
endmodule

// File: rtl/cam_capture_ctrl.sv
// Camera capture sequencer: arms the datapath, qualifies completion against vsync, arbitrates
// frame-buffer ownership with the CPU. CAM_CAPTURE_CTRL_TIMEOUT_EN adds the vsync timeout/ERROR path.
module cam_capture_ctrl
  import cam_ctrl_pkg::*;
#(
  parameter int TIMEOUT_FRAMES = TIMEOUT_FRAMES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic              pclk,
  input  logic              rst,
  cam_capture_ctrl_if.slave bus
);
  // state   | meaning
  // IDLE    | datapath off, waiting for start
  // ARM     | one cycle, qualifier/edge count/timeout freshly cleared
  // CAPTURE | datapath on, waiting for done_image after a vsync fall
  // HOLD    | frame held for CPU readout
  // ERROR   | vsync timeout, left by start or abort

  cam_state_e       state_q, state_d;
  logic             pend_q, pend_d;
  logic             qual_q;
  logic             gnt_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic [1:0]       edge_rise, edge_fall;
  logic             vsync_fall;
  logic             complete;
  logic             to_hit;
  logic             unused_edges;

  cam_edge_det #(.W(2)) u_edge_det (
    .pclk (pclk),
    .sig  ({bus.done_image, bus.vsync}),
    .rise (edge_rise),
    .fall (edge_fall)
  );

  assign vsync_fall   = edge_fall[0];
  assign unused_edges = ^{edge_rise, edge_fall[1]};

  // A sticky done_image only counts once a vsync fall has been seen in this capture.
  assign complete = (state_q == ST_CAPTURE) && bus.done_image && qual_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if ((bus.start || pend_q) && !bus.cpu_req) begin
          state_d = ST_ARM;
          pend_d  = 1'b0;
        end else if (bus.start) begin
          pend_d = 1'b1;
        end
      end
      ST_ARM:     state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (complete) begin
          state_d = (bus.mode && !bus.cpu_req) ? ST_ARM : ST_HOLD;
        end else if (to_hit) begin
          state_d = ST_ERROR;
        end
      end
      ST_ERROR: begin
        if (bus.start) state_d = ST_ARM;
      end
      default:    state_d = ST_IDLE;
    endcase
    if (bus.abort) begin
      state_d = ST_IDLE;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      qual_q      <= 1'b0;
      gnt_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      gnt_q   <= grant_state(state_d) && bus.cpu_req;
      if (state_d == ST_ARM) begin
        qual_q <= 1'b0;
      end else if ((state_q == ST_CAPTURE) && vsync_fall) begin
        qual_q <= 1'b1;
      end
      if (bus.irq) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
    end
  end

  assign bus.irq       = complete && !bus.abort && rst;
  assign bus.cam_init  = rst && ((state_q == ST_ARM) || (state_q == ST_CAPTURE));
  assign bus.busy      = (state_q == ST_ARM) || (state_q == ST_CAPTURE);
  assign bus.cpu_gnt   = gnt_q;
  assign bus.frame_cnt = frame_cnt_q;

`ifdef CAM_CAPTURE_CTRL_TIMEOUT_EN
  localparam int EC_W = $clog2(TIMEOUT_FRAMES + 1);

  logic [EC_W-1:0] edge_cnt_q;
  logic            timeout_q;

  // Threshold is the fall that brings the count up to TIMEOUT_FRAMES; completion wins in the FSM.
  assign to_hit = (state_q == ST_CAPTURE) && vsync_fall &&
                  (edge_cnt_q == EC_W'(TIMEOUT_FRAMES - 1));

  always_ff @(posedge pclk) begin
    if (!rst) begin
      edge_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else if (state_d == ST_ARM) begin
      edge_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if ((state_q == ST_CAPTURE) && vsync_fall) edge_cnt_q <= edge_cnt_q + EC_W'(1);
      if ((state_q == ST_CAPTURE) && (state_d == ST_ERROR)) timeout_q <= 1'b1;
    end
  end

  assign bus.timeout = timeout_q;
`else
  localparam int unused_timeout_frames = TIMEOUT_FRAMES;

  assign to_hit      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

endmodule
